// File: rtl/fnd_pkg.sv
// Shared constants, conversion state enum and the double-dabble nibble adjust for the FND scan path.
// No logic or state of its own, so no latency and no backpressure.
package fnd_pkg;
  localparam int DIGITS       = 4;
  localparam int BCD_W        = 4;
  localparam int VALUE_W      = 14;
  localparam int MAX_VALUE    = 9999;
  localparam int SHIFT_CYCLES = 14;
  localparam int ACC_W        = DIGITS * BCD_W;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_e;

  // Add 3 to every nibble that is 5 or more, so that the following shift carries into the next digit.
  function automatic logic [ACC_W-1:0] dd_adjust(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    r = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[k*BCD_W +: BCD_W] >= 4'd5) begin
        r[k*BCD_W +: BCD_W] = acc[k*BCD_W +: BCD_W] + 4'd3;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble conversion: start is taken in IDLE, 14 shift cycles follow, then done is high for one COMMIT cycle.
// busy is high from the start edge to the commit edge, and start is ignored whenever busy is high.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   bcd
);

  conv_state_e                state_q, state_d;
  logic [VALUE_W-1:0]         bin_q, bin_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [ACC_W+VALUE_W-1:0]   shifted;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {dd_adjust(acc_q), bin_q} << 1;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          bin_d   = value;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        {acc_d, bin_d} = shifted;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_CYCLES - 1)) begin
          done_d  = 1'b1;
          state_d = CONV_COMMIT;
        end
      end
      CONV_COMMIT: begin
        busy_d  = 1'b0;
        state_d = CONV_IDLE;
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = acc_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// Clamps and converts a binary value to four BCD digits and scans one digit per REFRESH_DIV cycles, with all outputs registered.
// Conversion takes 15 cycles and the new digits are visible 16 cycles after i_Load; a load that arrives while busy is dropped.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [VALUE_W-1:0] i_Value,
  input  logic               i_Load,
  input  logic               i_DisplayOn,
  output logic               o_Busy,
  output logic               o_Overflow,
  output logic [1:0]         o_DigitSelect,
  output logic [BCD_W-1:0]   o_BCD,
  output logic               o_EN
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic               conv_busy, conv_done;
  logic [ACC_W-1:0]   conv_bcd;
  logic               accept, over;
  logic [VALUE_W-1:0] clamped;

  logic               overflow_q, overflow_d;
  logic [ACC_W-1:0]   digits_q, digits_d;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         sel_q, sel_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               en_q, en_d;

  logic [BCD_W-1:0]   dig [DIGITS];
  logic [DIGITS-1:0]  blank;
  logic               upper_zero;
  logic               wrap;

  assign over    = (i_Value > VALUE_W'(MAX_VALUE));
  assign clamped = over ? VALUE_W'(MAX_VALUE) : i_Value;
  assign accept  = i_Load & ~conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .start (accept),
    .value (clamped),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    overflow_d = accept ? over : overflow_q;
    digits_d   = conv_done ? conv_bcd : digits_q;

    wrap   = (tick_q == CNT_W'(REFRESH_DIV - 1));
    tick_d = wrap ? '0 : tick_q + CNT_W'(1);
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;

    for (int k = 0; k < DIGITS; k++) begin
      dig[k] = digits_q[k*BCD_W +: BCD_W];
    end

    // Digit k is blanked only when it and every digit above it are zero; the ones digit is always shown.
    upper_zero = 1'b1;
    blank      = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (dig[k] == '0);
      blank[k]   = BLANK_LEADING & upper_zero;
    end

    // Every output is computed from the next index, so select, code and enable always move together on one edge.
    sel_d = idx_d;
    bcd_d = dig[idx_d];
    en_d  = ~i_DisplayOn | blank[idx_d];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overflow_q <= 1'b0;
      digits_q   <= '0;
      tick_q     <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      bcd_q      <= '0;
      en_q       <= 1'b1;
    end else begin
      overflow_q <= overflow_d;
      digits_q   <= digits_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      bcd_q      <= bcd_d;
      en_q       <= en_d;
    end
  end

  assign o_Busy        = conv_busy;
  assign o_Overflow    = overflow_q;
  assign o_DigitSelect = sel_q;
  assign o_BCD         = bcd_q;
  assign o_EN          = en_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with REFRESH_DIV=4, driving one instance with leading-zero blanking and one without.
// The inputs are driven and the outputs sampled on the falling clock edge.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] value;
  logic        load_i;
  logic        disp_on;

  logic       busy, ovf, en;
  logic [1:0] sel;
  logic [3:0] bcd;
  logic       busy_n, ovf_n, en_n;
  logic [1:0] sel_n;
  logic [3:0] bcd_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_Value(value), .i_Load(load_i), .i_DisplayOn(disp_on),
    .o_Busy(busy), .o_Overflow(ovf), .o_DigitSelect(sel), .o_BCD(bcd), .o_EN(en)
  );

  fnd_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
    .i_clk(clk), .i_reset_n(reset_n), .i_Value(value), .i_Load(load_i), .i_DisplayOn(disp_on),
    .o_Busy(busy_n), .o_Overflow(ovf_n), .o_DigitSelect(sel_n), .o_BCD(bcd_n), .o_EN(en_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_digit(input int v, input int k);
    int c;
    c = (v > 9999) ? 9999 : v;
    for (int i = 0; i < k; i++) c = c / 10;
    return c % 10;
  endfunction

  function automatic bit exp_lit_blank(input int v, input int k);
    int c;
    int p;
    c = (v > 9999) ? 9999 : v;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return (k == 0) || (c >= p);
  endfunction

  task automatic load(input int v);
    @(negedge clk);
    value  = 14'(v);
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  // Starts at the falling edge after the load edge and returns at the first falling edge that sees busy low.
  task automatic busy_len(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check(tag, n, 15);
  endtask

  task automatic show(input int v, input bit on, input int ncyc);
    logic [1:0] prev;
    logic [1:0] nxt;
    int         run;
    bit         seen;
    prev = '0;
    run  = 0;
    seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("sel_pair", sel_n, sel);
      check("bcd", bcd, exp_digit(v, sel));
      check("bcd_nb", bcd_n, exp_digit(v, sel_n));
      check("en", en, (on && exp_lit_blank(v, sel)) ? 0 : 1);
      check("en_nb", en_n, on ? 0 : 1);
      if (i > 0 && sel != prev) begin
        nxt = prev + 2'd1;
        check("sel_step", sel, nxt);
        if (seen) check("sel_hold", run, 4);
        seen = 1'b1;
        run  = 1;
      end else begin
        run++;
      end
      prev = sel;
    end
  endtask

  initial begin
    int changes;
    logic [1:0] last;

    reset_n = 1'b0;
    value   = '0;
    load_i  = 1'b0;
    disp_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sel", sel, 0);
    check("rst_bcd", bcd, 0);
    check("rst_en", en, 1);
    check("rst_en_nb", en_n, 1);
    reset_n = 1'b1;
    show(0, 1'b1, 12);

    // Reset in the middle of a saturating conversion.
    load(16383);
    check("mid_ovf", ovf, 1);
    check("mid_busy", busy, 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ovf", ovf, 0);
    check("arst_sel", sel, 0);
    check("arst_bcd", bcd, 0);
    check("arst_en", en, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ovf", ovf, 0);
    show(0, 1'b1, 12);

    load(1234);
    check("ovf_1234", ovf, 0);
    busy_len("busy_1234");
    show(1234, 1'b1, 20);

    load(16383);
    check("ovf_sat", ovf, 1);
    check("ovf_sat_nb", ovf_n, 1);
    busy_len("busy_sat");
    show(16383, 1'b1, 20);

    load(5);
    check("ovf_clear", ovf, 0);
    busy_len("busy_5");
    show(5, 1'b1, 20);

    load(7);
    busy_len("busy_7");
    show(7, 1'b1, 20);

    load(1002);
    busy_len("busy_1002");
    show(1002, 1'b1, 20);

    load(1234);
    busy_len("busy_1234b");
    show(1234, 1'b1, 8);

    // A second load at E5 must be dropped and the old digits held until commit.
    load(5678);
    for (int j = 0; j < 15; j++) begin
      check("drop_busy", busy, 1);
      check("drop_hold", bcd, exp_digit(1234, sel));
      if (j == 4) begin
        value  = 14'd9999;
        load_i = 1'b1;
      end
      @(negedge clk);
      load_i = 1'b0;
    end
    check("drop_done", busy, 0);
    check("drop_hold_end", bcd, exp_digit(1234, sel));
    show(5678, 1'b1, 20);
    check("drop_ovf", ovf, 0);

    disp_on = 1'b0;
    last    = sel;
    changes = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("off_en", en, 1);
      check("off_en_nb", en_n, 1);
      if (sel != last) changes++;
      last = sel;
    end
    check("off_scan", changes, 2);
    disp_on = 1'b1;
    @(negedge clk);
    check("on_en", en, 0);
    check("on_en_nb", en_n, 0);
    show(5678, 1'b1, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Upstream driver for the FND digit-select decoder and BCD-to-FND font decoder. Accepts a 14-bit binary value (such as the 4-bit adder result widened), converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits. Each refresh tick it presents one digit's BCD code plus a 2-bit digit select and an active-low enable that feed both decoders directly.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal ≥ 2.
- `BLANK_LEADING`, 1: 1 = suppress leading zeros (digit 0 never blanked); 0 = show all four digits.
- `i_clk`  in  1  system clock, rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_Value`  in  14  unsigned binary value to display.
- `i_Load`  in  1  single-cycle strobe: capture `i_Value` and start conversion.
- `i_DisplayOn`  in  1  1 = display enabled; 0 = force all digits off.
- `o_Busy`  out  1  conversion in progress; `i_Load` ignored while high.
- `o_Overflow`  out  1  last loaded value exceeded 9999 (saturated).
- `o_DigitSelect`  out  2  digit index to the select decoder (00 = ones … 11 = thousands).
- `o_BCD`  out  4  BCD code of the selected digit to the font decoder.
- `o_EN`  out  1  active-low enable to both decoders (0 = lit).

## Operation
- Conversion FSM, states IDLE → SHIFT → COMMIT → IDLE.
- IDLE: on `i_Load`=1, capture min(`i_Value`, 9999) into the shift register, clear the BCD accumulator, load `o_Overflow` = (`i_Value` > 9999), and go to SHIFT.
- SHIFT: exactly 14 cycles. Each cycle, every BCD nibble ≥ 5 gets +3, then the combined {BCD, binary} register shifts left by 1.
- COMMIT: copy the 16-bit accumulator into the display digit register in one cycle, then go to IDLE. Display digits never show a partial conversion.
- `i_Load` in SHIFT or COMMIT is dropped. No queueing.
- Scanner runs independently of the FSM.
  - Tick counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0→1→2→3→0.
- Blanking, when BLANK_LEADING=1: digit k (k = 1..3) is blanked if digits k..3 are all zero. Value 0 shows a single "0".
- `o_EN` = 1 when `i_DisplayOn`=0 or the selected digit is blanked; otherwise 0.
- Arithmetic: nibble add is 4-bit. Inputs are always ≤ 9999, so 16 BCD bits are sufficient.

## Timing
- Reset (asynchronous, immediate) values:
  - FSM IDLE; tick counter 0; index 0; digits 0.
  - `o_Busy`=0, `o_Overflow`=0, `o_DigitSelect`=00, `o_BCD`=0, `o_EN`=1.
- All outputs are registered.
  - `o_DigitSelect`, `o_BCD` and `o_EN` update on the same edge as the index, so there are no mixed-digit cycles.
  - Otherwise `o_BCD` and `o_EN` re-register every cycle. A committed digit or a `i_DisplayOn` change therefore shows on the next edge.
- Load latency:
  - `i_Load` is sampled at edge E0; shifts occur at E1..E14; commit at E15.
  - `o_Busy` is high after E0 and low after E15.
  - The new digit is visible on `o_BCD` after E16 (when that digit is selected).
  - The next `i_Load` is accepted at E16 or later.
- `i_Load` on the same edge as a scan wrap: both actions occur. The scan uses the old digits until COMMIT.
- Reset mid-conversion aborts the conversion. Digits and `o_Overflow` return to 0.

## Structure
- Package `fnd_pkg`:
  - constants DIGITS=4, BCD_W=4, VALUE_W=14, MAX_VALUE=9999, SHIFT_CYCLES=14;
  - conversion state enum.
- Sub-module `bin2bcd_seq`: contains the FSM plus double-dabble datapath, with ports start/busy/done/bcd[15:0].
- The top level holds the clamp, digit register, refresh counter, index, blanking and output registers.

## Test plan
All cases use REFRESH_DIV=4.
- Reset behaviour: assert `i_reset_n`=0 mid-run → all outputs at reset values immediately. Release, keep `i_DisplayOn`=1 → only digit 0 lit (`o_EN`=0, `o_BCD`=0); indices 1–3 have `o_EN`=1.
- Conversion: load 1234 → `o_Busy` high for 15 cycles. Scan then yields select 00/01/10/11 with BCD 4/3/2/1, each held 4 cycles, and `o_EN`=0 throughout.
- Saturation: load 16383 → `o_Overflow`=1 and the display shows 9999. A subsequent load of 5 → `o_Overflow`=0.
- Leading blank: load 7 with BLANK_LEADING=1 → `o_EN`=0 only at select 00. With BLANK_LEADING=0 → all four digits lit, digits 1–3 show 0. Load 1002 → all four digits lit.
- Busy drop: with 1234 displayed, load 5678, then pulse `i_Load`=1 with 9999 at E5 → result is 5678. Digits stay 1234 until commit.
- Display gate: `i_DisplayOn`=0 → `o_EN`=1 for every index one edge later while the scan continues. Re-enable → lit on the next edge.
